chan_scanner: RTL and testbench
===============================

CHAN_SCANNER -- requirements
Module: chan_scanner

Interface
REQ-001 Parameter: DWELL_W, default 8, width of dwell counter and dwell input.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  begin scan when in IDLE; ignored otherwise.
REQ-005 stop  in  1  abort scan; returns to IDLE.
REQ-006 single  in  1  sampled with start: 1 = one pass, 0 = continuous.
REQ-007 en_mask  in  8  channels to visit; sampled with start.
REQ-008 dwell  in  DWELL_W  cycles per channel, sampled with start; 0 treated as 1.
REQ-009 sel_ready  in  1  downstream 3-to-8 decode stage accepts current index.
REQ-010 sel_idx  out  3  current channel index, binary, feeds the decoder's select input.
REQ-011 sel_valid  out  1  sel_idx is meaningful.
REQ-012 busy  out  1  high in SCAN state.
REQ-013 done  out  1  one-cycle pulse at end of a single pass.
REQ-014 err  out  1  one-cycle pulse when start is rejected.

Function
REQ-015 FSM states: IDLE, SCAN; the block SHALL hold no other states.
REQ-016 IDLE, start=1, stop=0, en_mask!=0: latch en_mask, dwell, single; sel_idx <= lowest set bit; cnt <= 0; go to SCAN; sel_valid=busy=1 from the next cycle.
REQ-017 IDLE, start=1, en_mask==0: stay IDLE; err=1 for exactly the following cycle.
REQ-018 SCAN: cnt increments only in cycles where sel_ready=1; with sel_ready=0, sel_idx and cnt hold (stall).
REQ-019 SCAN, sel_ready=1, cnt==dwell_eff-1: cnt <= 0; sel_idx <= next set bit of latched mask strictly above sel_idx, wrapping to the lowest set bit.
REQ-020 Single pass: when the advance of REQ-019 would wrap, go to IDLE instead; sel_valid=busy=0 and done=1 in the next cycle.
REQ-021 Continuous mode: wrap continues indefinitely; a one-bit mask keeps sel_idx constant, cnt restarting every dwell_eff accepted cycles.
REQ-022 stop=1 in SCAN: IDLE next cycle; no done pulse; stop and start in the same cycle: stop wins.
REQ-023 start in SCAN is ignored; changes to en_mask, dwell and single after start have no effect until the next accepted start.
REQ-024 In IDLE, sel_idx holds its last value; sel_valid=0.

Reset
REQ-025 rst=1 at any clock edge, including mid-scan: state=IDLE, cnt=0, sel_idx=0, sel_valid=0, busy=0, done=0, err=0, latched mask=0; rst overrides start and stop.

Configuration
REQ-026 Macro SCAN_WRAP_EN defined: extra outputs wrap (1-cycle pulse on each continuous-mode wrap) and pass_cnt[7:0] (counts wraps, saturates at 255, cleared on accepted start and rst).
REQ-027 SCAN_WRAP_EN undefined: wrap and pass_cnt ports and logic are absent; all other behaviour identical.

Structure
REQ-028 Package scan_pkg SHALL hold the state enum (IDLE, SCAN), NCH=8, IDX_W=3.
REQ-029 Sub-module next_chan_find (combinational: mask, current index -> next index, wrap flag) SHALL be instantiated once.

Verification
REQ-030 mask=8'b1010_0100, dwell=2, single=1, ready=1: sel_idx 2,2,5,5,7,7 then done pulse; busy low after.
REQ-031 mask=0, start: err pulse one cycle; busy stays 0.
REQ-032 mask=8'h81, dwell=0, continuous: sel_idx alternates 0,7 each cycle; with SCAN_WRAP_EN, wrap pulses on 7->0 and pass_cnt increments.
REQ-033 dwell=3, sel_ready low 4 cycles mid-dwell: sel_idx held for 7 cycles total.
REQ-034 stop asserted with start in IDLE: no scan; rst mid-scan: all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scanner.
// Holds the FSM state enum, channel count NCH and index width IDX_W.
package scan_pkg;

    localparam int NCH   = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/next_chan_find.sv
// Combinational search for the next enabled channel above cur_i.
// Ports: mask_i (enabled channels), cur_i (current index),
//        next_o (next enabled index), wrap_o (search wrapped to lowest bit).
module next_chan_find
    import scan_pkg::*;
(
    input  logic [NCH-1:0]   mask_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] next_o,
    output logic             wrap_o
);

    always_comb begin
        next_o = cur_i;
        wrap_o = 1'b1;
        // Lowest set bit: the wrap target.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                next_o = IDX_W'(i);
            end
        end
        // Lowest set bit strictly above cur_i overrides the wrap target.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                next_o = IDX_W'(i);
                wrap_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/chan_scanner.sv
// Channel scanner: steps sel_idx through the enabled channels of a latched
// mask, dwelling dwell accepted cycles on each, in single-pass or continuous
// mode, handshaking with a downstream 3-to-8 decoder via sel_valid/sel_ready.
// Ports: clk, rst (sync, active-high), start, stop, single, en_mask, dwell,
//        sel_ready in; sel_idx, sel_valid, busy, done, err out.
// Optional macro SCAN_WRAP_EN adds outputs wrap (pulse on continuous-mode
// wrap) and pass_cnt (saturating wrap count, cleared on accepted start).
module chan_scanner
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [NCH-1:0]     en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               sel_ready,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef SCAN_WRAP_EN
    ,
    output logic               wrap,
    output logic [7:0]         pass_cnt
`endif
);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic               single_q, single_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NCH-1:0]     f_mask;
    logic [IDX_W-1:0]   f_cur, f_next;
    logic               f_wrap;
    logic               last_beat;

    // In IDLE the finder is searched from index 7 with the live mask, which
    // yields the lowest set bit for the start; in SCAN it walks the latched mask.
    assign f_mask = (state_q == IDLE) ? en_mask : mask_q;
    assign f_cur  = (state_q == IDLE) ? IDX_W'(NCH - 1) : idx_q;

    next_chan_find u_find (
        .mask_i (f_mask),
        .cur_i  (f_cur),
        .next_o (f_next),
        .wrap_o (f_wrap)
    );

    assign last_beat = sel_ready && (cnt_q == dwell_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dwell_q  <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            single_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            single_q <= single_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        single_d = single_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (en_mask != '0) begin
                        state_d  = SCAN;
                        mask_d   = en_mask;
                        dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
                        single_d = single;
                        idx_d    = f_next;
                        cnt_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last_beat) begin
                    cnt_d = '0;
                    if (f_wrap && single_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = f_next;
                    end
                end else if (sel_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_idx   = idx_q;
    assign sel_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign err       = err_q;

`ifdef SCAN_WRAP_EN
    logic       accept;
    logic       adv_wrap;
    logic       wrap_q;
    logic [7:0] pass_q;

    assign accept   = (state_q == IDLE) && start && !stop && (en_mask != '0);
    assign adv_wrap = (state_q == SCAN) && !stop && last_beat
                      && f_wrap && !single_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
            pass_q <= '0;
        end else begin
            wrap_q <= adv_wrap;
            if (accept) begin
                pass_q <= '0;
            end else if (adv_wrap && (pass_q != 8'hFF)) begin
                pass_q <= pass_q + 8'd1;
            end
        end
    end

    assign wrap     = wrap_q;
    assign pass_cnt = pass_q;
`endif

endmodule

// File: tb/tb_chan_scanner.sv
// Directed self-checking bench for chan_scanner.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_chan_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] en_mask;
    logic [7:0] dwell;
    logic       sel_ready;
    logic [2:0] sel_idx;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SCAN_WRAP_EN
    logic       wrap;
    logic [7:0] pass_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    chan_scanner #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .single    (single),
        .en_mask   (en_mask),
        .dwell     (dwell),
        .sel_ready (sel_ready),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef SCAN_WRAP_EN
        ,
        .wrap      (wrap),
        .pass_cnt  (pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0;
        en_mask = 8'h00; dwell = 8'd1; sel_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({sel_idx, sel_valid, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {sel_idx, sel_valid, busy, done, err}, 7'b0);
        end
`ifdef SCAN_WRAP_EN
        checks++;
        if ({wrap, pass_cnt} !== 9'b0) begin
            failures++;
            $display("FAIL reset_wrap got=%h exp=0", {wrap, pass_cnt});
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        int exp_idx [6] = '{2, 2, 5, 5, 7, 7};
        en_mask = 8'b1010_0100; dwell = 8'd2; single = 1'b1;
        sel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; en_mask = 8'hFF; dwell = 8'd9;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) tick();
            checks++;
            if (sel_idx !== 3'(exp_idx[k]) || busy !== 1'b1 ||
                sel_valid !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL single_step%0d idx=%0d busy=%b vld=%b done=%b exp idx=%0d busy=1 vld=1 done=0",
                         k, sel_idx, busy, sel_valid, done, exp_idx[k]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sel_valid !== 1'b0 ||
            sel_idx !== 3'd7) begin
            failures++;
            $display("FAIL single_done done=%b busy=%b vld=%b idx=%0d exp 1 0 0 7",
                     done, busy, sel_valid, sel_idx);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sel_idx !== 3'd7) begin
            failures++;
            $display("FAIL single_after done=%b busy=%b idx=%0d exp 0 0 7",
                     done, busy, sel_idx);
        end
    endtask

    task automatic test_one_bit_single();
        en_mask = 8'h10; dwell = 8'd1; single = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (sel_idx !== 3'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL onebit_start idx=%0d busy=%b exp 4 1", sel_idx, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sel_idx !== 3'd4) begin
            failures++;
            $display("FAIL onebit_done done=%b busy=%b idx=%0d exp 1 0 4",
                     done, busy, sel_idx);
        end
        tick();
    endtask

    task automatic test_err();
        en_mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse err=%b busy=%b vld=%b exp 1 0 0",
                     err, busy, sel_valid);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b busy=%b exp 0 0", err, busy);
        end
    endtask

    task automatic test_continuous();
        int exp_idx  [6] = '{0, 7, 0, 7, 0, 7};
`ifdef SCAN_WRAP_EN
        int exp_wrap [6] = '{0, 0, 1, 0, 1, 0};
        int exp_pass [6] = '{0, 0, 1, 1, 2, 2};
`endif
        en_mask = 8'h81; dwell = 8'd0; single = 1'b0;
        sel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) tick();
            checks++;
            if (sel_idx !== 3'(exp_idx[k]) || busy !== 1'b1 ||
                done !== 1'b0) begin
                failures++;
                $display("FAIL cont_step%0d idx=%0d busy=%b done=%b exp idx=%0d busy=1 done=0",
                         k, sel_idx, busy, done, exp_idx[k]);
            end
`ifdef SCAN_WRAP_EN
            checks++;
            if (wrap !== 1'(exp_wrap[k]) || pass_cnt !== 8'(exp_pass[k])) begin
                failures++;
                $display("FAIL cont_wrap%0d wrap=%b pass=%0d exp %0d %0d",
                         k, wrap, pass_cnt, exp_wrap[k], exp_pass[k]);
            end
`endif
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || sel_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop busy=%b vld=%b done=%b exp 0 0 0",
                     busy, sel_valid, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop_nodone done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        int exp_idx [9] = '{1, 1, 1, 1, 1, 1, 1, 2, 2};
        int rdy     [9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
        int held = 0;
        en_mask = 8'b0000_0110; dwell = 8'd3; single = 1'b1;
        sel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) tick();
            checks++;
            if (sel_idx !== 3'(exp_idx[k]) || busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_step%0d idx=%0d busy=%b exp idx=%0d busy=1",
                         k, sel_idx, busy, exp_idx[k]);
            end
            if (sel_idx === 3'd1) held++;
            sel_ready = 1'(rdy[k]);
            // a start with a new mask during the scan must be ignored
            start = (k == 2);
            en_mask = (k == 2) ? 8'h80 : 8'b0000_0110;
        end
        checks++;
        if (held != 7) begin
            failures++;
            $display("FAIL stall_hold held=%0d exp=7", held);
        end
        stop = 1'b1; start = 1'b0;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_stop_start_idle();
        en_mask = 8'hFF; dwell = 8'd1; single = 1'b0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || sel_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL stop_start busy=%b vld=%b err=%b exp 0 0 0",
                     busy, sel_valid, err);
        end
    endtask

    task automatic test_rst_mid();
        en_mask = 8'h0F; dwell = 8'd4; single = 1'b1;
        sel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || sel_idx !== 3'd0) begin
            failures++;
            $display("FAIL rst_pre busy=%b idx=%0d exp 1 0", busy, sel_idx);
        end
        tick(); tick(); tick();
        checks++;
        if (sel_idx !== 3'd1) begin
            failures++;
            $display("FAIL rst_pre_adv idx=%0d exp 1", sel_idx);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({sel_idx, sel_valid, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=%b",
                     {sel_idx, sel_valid, busy, done, err}, 7'b0);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_nodone done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_one_bit_single();
        test_err();
        test_continuous();
        test_stall();
        test_stop_start_idle();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
